// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-memory path: FSM and op encodings, default widths.
package cache_pkg;
  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY
  } arb_state_t;
endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Combinational two-request round-robin picker: on a tie the requester other than last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);
  assign gnt = (req[0] & req[1]) ? ~last : req[1];
endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache (m0) and D-cache (m1).
// Optional ARB_TIMEOUT_EN aborts a stalled BUSY transaction with err after 2^TO_W-1 idle memory cycles.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TO_W   = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              m0_op,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_op,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_op,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_t        state;
  logic              grant;
  logic              last_grant;
  logic              pick;
  logic              busy;
  logic              done;
  logic              to_hit;
  logic [DATA_W-1:0] rdata;

  rr_arb2 u_rr (
    .req  ({m1_valid, m0_valid}),
    .last (last_grant),
    .gnt  (pick)
  );

  assign busy      = (state == ST_BUSY);
  assign mem_valid = busy;
  assign done      = busy & (mem_ready | to_hit);

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Counter is held at zero outside BUSY, so it starts fresh on every grant.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      to_cnt <= '0;
    end else if (!busy) begin
      to_cnt <= '0;
    end else if (!mem_ready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = busy & (&to_cnt) & ~mem_ready;
`else
  assign to_hit = (TO_W < 0);
`endif

  // A timeout abort returns zero data even on reads.
  assign rdata = (busy & mem_ready & (mem_op == OP_READ)) ? mem_rdata : '0;

  assign m0_ready = done & ~grant;
  assign m1_ready = done & grant;
  assign m0_rdata = grant ? '0 : rdata;
  assign m1_rdata = grant ? rdata : '0;
  assign m0_err   = to_hit & ~grant;
  assign m1_err   = to_hit & grant;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mem_op     <= OP_WRITE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_valid | m1_valid) begin
            grant     <= pick;
            mem_op    <= pick ? m1_op    : m0_op;
            mem_addr  <= pick ? m1_addr  : m0_addr;
            mem_wdata <= pick ? m1_wdata : m0_wdata;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: vector table plus multi-cycle sequences (tie, fairness,
// stability, reset abort, and the ARB_TIMEOUT_EN abort when that macro is defined).
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif

  logic          clk;
  logic          nrst;
  logic          m0_op, m0_valid, m0_ready, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_op, m1_valid, m1_ready, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_op, mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TO_W(TW)) dut (
    .clk(clk), .nrst(nrst),
    .m0_op(m0_op), .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_op(m1_op), .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_op(mem_op), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic m0v; logic m0op; logic [31:0] m0a; logic [31:0] m0w;
    logic m1v; logic m1op; logic [31:0] m1a; logic [31:0] m1w;
    logic mr;  logic [31:0] mrd;
    logic ev;  logic eop;  logic [31:0] ea;  logic [31:0] ew;
    logic e0r; logic [31:0] e0d;
    logic e1r; logic [31:0] e1d;
  } vec_t;

  vec_t vt[10];

  task automatic clear_inputs();
    m0_op = 1'b0; m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_op = 1'b0; m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    clear_inputs();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // Advances to the first negedge (+1) where mem_valid is high; leaves us there.
  task automatic wait_busy(input string name);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (mem_valid) return;
    end
    chk({name, " busy timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    nrst = 1'b0;
    clear_inputs();
    #2;
    chk("rst mem_valid", mem_valid, 0);
    chk("rst mem_op", mem_op, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst ready", {m0_ready, m1_ready, m0_err, m1_err}, 0);
    chk("rst rdata", {m0_rdata, m1_rdata}, 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

    // Single m0 read, mem_ready on 4th BUSY cycle, IDLE mem_ready ignored, then an m1 write.
    vt[0] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,
              1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    vt[1] = '{1'b1,1'b1,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,
              1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    vt[2] = '{1'b1,1'b1,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,
              1'b1,1'b1,32'h100,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    vt[3] = vt[2];
    vt[4] = vt[2];
    vt[5] = '{1'b1,1'b1,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,32'hDEADBEEF,
              1'b1,1'b1,32'h100,32'h0, 1'b1,32'hDEADBEEF, 1'b0,32'h0};
    vt[6] = '{1'b0,1'b1,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,32'hCAFE,
              1'b0,1'b1,32'h100,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    vt[7] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h20,32'h55AA, 1'b0,32'h0,
              1'b0,1'b1,32'h100,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    vt[8] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h20,32'h55AA, 1'b1,32'h1234,
              1'b1,1'b0,32'h20,32'h55AA, 1'b0,32'h0, 1'b1,32'h0};
    vt[9] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,
              1'b0,1'b0,32'h20,32'h55AA, 1'b0,32'h0, 1'b0,32'h0};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m0_valid = vt[i].m0v; m0_op = vt[i].m0op; m0_addr = vt[i].m0a; m0_wdata = vt[i].m0w;
      m1_valid = vt[i].m1v; m1_op = vt[i].m1op; m1_addr = vt[i].m1a; m1_wdata = vt[i].m1w;
      mem_ready = vt[i].mr; mem_rdata = vt[i].mrd;
      #1;
      chk($sformatf("v%0d mem_valid", i), mem_valid, vt[i].ev);
      chk($sformatf("v%0d mem_op", i), mem_op, vt[i].eop);
      chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].ea);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].ew);
      chk($sformatf("v%0d m0_ready", i), m0_ready, vt[i].e0r);
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, vt[i].e0d);
      chk($sformatf("v%0d m1_ready", i), m1_ready, vt[i].e1r);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, vt[i].e1d);
      chk($sformatf("v%0d err", i), {m0_err, m1_err}, 0);
    end

    // Tie right after reset: m0 first, one bubble, then m1 write.
    do_reset();
    @(negedge clk);
    m0_valid = 1'b1; m0_op = 1'b1; m0_addr = 32'h10;
    m1_valid = 1'b1; m1_op = 1'b0; m1_addr = 32'h20; m1_wdata = 32'h55AA;
    #1;
    chk("tie idle mem_valid", mem_valid, 0);
    @(negedge clk);
    #1;
    chk("tie m0 addr", {mem_valid, mem_op, mem_addr}, {1'b1, 1'b1, 32'h10});
    mem_ready = 1'b1; mem_rdata = 32'hA5A5;
    #1;
    chk("tie m0 done", {m0_ready, m1_ready, m0_rdata}, {1'b1, 1'b0, 32'hA5A5});
    @(negedge clk);
    m0_valid = 1'b0; mem_ready = 1'b0;
    #1;
    chk("tie bubble", {mem_valid, m0_ready, m1_ready}, 0);
    @(negedge clk);
    #1;
    chk("tie m1 write", {mem_valid, mem_op, mem_addr, mem_wdata},
        {1'b1, 1'b0, 32'h20, 32'h55AA});
    mem_ready = 1'b1; mem_rdata = 32'h9999;
    #1;
    chk("tie m1 done", {m1_ready, m0_ready, m1_rdata}, {1'b1, 1'b0, 32'h0});
    @(negedge clk);
    clear_inputs();

    // Fairness: both masters hold valid through every completion.
    do_reset();
    m0_valid = 1'b1; m0_op = 1'b1; m0_addr = 32'hA0;
    m1_valid = 1'b1; m1_op = 1'b1; m1_addr = 32'hB0;
    for (int t = 0; t < 6; t++) begin
      mem_ready = 1'b0;
      wait_busy($sformatf("fair%0d", t));
      mem_ready = 1'b1;
      #1;
      chk($sformatf("fair%0d grant", t), {m1_ready, m0_ready},
          (t % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      mem_ready = 1'b0;
    end
    clear_inputs();

    // Mid-BUSY address change and valid drop are ignored.
    @(negedge clk);
    m0_valid = 1'b1; m0_op = 1'b1; m0_addr = 32'h300;
    wait_busy("stab");
    m0_addr = 32'h999; m0_valid = 1'b0;
    #1;
    chk("stab addr a", mem_addr, 32'h300);
    @(negedge clk);
    #1;
    chk("stab addr b", {mem_valid, mem_addr}, {1'b1, 32'h300});
    mem_ready = 1'b1; mem_rdata = 32'h77;
    #1;
    chk("stab done", {m0_ready, m0_rdata}, {1'b1, 32'h77});
    @(negedge clk);
    clear_inputs();

    // Reset in BUSY: immediate abort, then m0 wins the following tie.
    @(negedge clk);
    m1_valid = 1'b1; m1_op = 1'b0; m1_addr = 32'h40; m1_wdata = 32'h11;
    wait_busy("rstb");
    mem_ready = 1'b1;
    nrst = 1'b0;
    m1_valid = 1'b0;
    #1;
    chk("rstb abort", {mem_valid, m0_ready, m1_ready}, 0);
    chk("rstb regs", {mem_addr, mem_wdata}, 0);
    @(negedge clk);
    nrst = 1'b1; mem_ready = 1'b0;
    m0_valid = 1'b1; m0_op = 1'b1; m0_addr = 32'h50;
    m1_valid = 1'b1; m1_op = 1'b1; m1_addr = 32'h60;
    wait_busy("rstb tie");
    chk("rstb tie addr", mem_addr, 32'h50);
    mem_ready = 1'b1;
    #1;
    chk("rstb tie ready", {m1_ready, m0_ready}, 2'b01);
    @(negedge clk);
    clear_inputs();

`ifdef ARB_TIMEOUT_EN
    // Stalled memory: abort with err on the BUSY cycle where the counter reads 15.
    @(negedge clk);
    @(negedge clk);
    m1_valid = 1'b1; m1_op = 1'b1; m1_addr = 32'h70;
    wait_busy("to");
    begin
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        n++;
        if (m1_ready) begin
          seen = 1'b1;
          chk("to cycles", n, 16);
          chk("to err", {m1_err, m0_err, m0_ready}, 3'b100);
          chk("to rdata", m1_rdata, 0);
        end else begin
          @(negedge clk);
          #1;
        end
      end
      if (!seen) chk("to never fired", 0, 1);
    end
    @(negedge clk);
    m1_valid = 1'b0;
    @(negedge clk);
    m1_valid = 1'b1;
    wait_busy("to2");
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("to2 wait%0d", k), m1_ready, 0);
      @(negedge clk);
      #1;
    end
    mem_ready = 1'b1; mem_rdata = 32'hBEEF;
    #1;
    chk("to2 ready wins", {m1_ready, m1_err, m1_rdata}, {1'b1, 1'b0, 32'hBEEF});
    @(negedge clk);
    clear_inputs();
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
